// File: rtl/drbg_pkg.sv
// Shared CTR_DRBG constants and FSM state encoding for the instantiate, reseed
// and generate procedures.
package drbg_pkg;

    localparam int unsigned KEYLEN  = 256;
    localparam int unsigned BLKLEN  = 128;
    localparam int unsigned SEEDLEN = 384;

    localparam logic [31:0] RESEED_INTERVAL_DEFAULT = 32'd1024;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        GEN_INC,
        GEN_ENC,
        GEN_OUT,
        UPD_INC,
        UPD_ENC,
        UPD_DONE
    } state_e;

endpackage

// File: rtl/generate_proc.sv
// CTR_DRBG generate procedure with an external AES-256 cipher handshake.
// Optional additional input is enabled by defining DRBG_ADDIN_EN.
module generate_proc
    import drbg_pkg::*;
#(
    parameter logic [31:0] RESEED_INTERVAL = RESEED_INTERVAL_DEFAULT,
    parameter int unsigned MAX_BLOCKS      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEYLEN-1:0]  key_in,
    input  logic [BLKLEN-1:0]  value_in,
    input  logic [31:0]        reseedcounter_in,
    input  logic               load,
    input  logic               gen_req,
    input  logic [4:0]         num_blocks,
`ifdef DRBG_ADDIN_EN
    input  logic [SEEDLEN-1:0] addin,
`endif
    output logic               gen_busy,
    output logic               enc_req,
    output logic [KEYLEN-1:0]  enc_key,
    output logic [BLKLEN-1:0]  enc_in,
    input  logic               enc_ack,
    input  logic [BLKLEN-1:0]  enc_out,
    output logic [BLKLEN-1:0]  rand_block,
    output logic               rand_valid,
    input  logic               rand_ready,
    output logic               done,
    output logic               reseed_required,
    output logic               req_error,
    output logic [KEYLEN-1:0]  key_out,
    output logic [BLKLEN-1:0]  value_out,
    output logic [31:0]        reseedcounter_out
);

    state_e               state_q;
    logic [KEYLEN-1:0]    key_q;
    logic [BLKLEN-1:0]    val_q;
    logic [31:0]          ctr_q;
    logic [4:0]           blk_cnt_q;
    logic [1:0]           rnd_q;
    logic [SEEDLEN-1:0]   temp_q;
    logic                 pre_q;
    logic                 busy_q;
    logic                 enc_req_q;
    logic [BLKLEN-1:0]    rand_block_q;
    logic                 rand_valid_q;
    logic                 done_q;
    logic                 err_q;
    logic                 rsd_q;

`ifdef DRBG_ADDIN_EN
    logic [SEEDLEN-1:0]   addin_q;
`else
    logic [SEEDLEN-1:0]   addin_q;
    assign addin_q = '0;
`endif

    logic [SEEDLEN-1:0] upd_seed;
    logic               req_bad;

    assign upd_seed = temp_q ^ addin_q;
    assign req_bad  = (blk_cnt_q == 5'd0) || (32'(blk_cnt_q) > MAX_BLOCKS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            key_q        <= '0;
            val_q        <= '0;
            ctr_q        <= 32'd1;
            blk_cnt_q    <= '0;
            rnd_q        <= '0;
            temp_q       <= '0;
            pre_q        <= 1'b0;
            busy_q       <= 1'b0;
            enc_req_q    <= 1'b0;
            rand_block_q <= '0;
            rand_valid_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rsd_q        <= 1'b0;
`ifdef DRBG_ADDIN_EN
            addin_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            rsd_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        key_q <= key_in;
                        val_q <= value_in;
                        ctr_q <= reseedcounter_in;
                    end else if (gen_req) begin
                        blk_cnt_q <= num_blocks;
                        busy_q    <= 1'b1;
                        state_q   <= CHECK;
`ifdef DRBG_ADDIN_EN
                        addin_q   <= addin;
`endif
                    end
                end
                CHECK: begin
                    if (req_bad) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (ctr_q > RESEED_INTERVAL) begin
                        rsd_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (addin_q != '0) begin
                        // Mix the additional input into K/V before any output.
                        pre_q   <= 1'b1;
                        rnd_q   <= '0;
                        state_q <= UPD_INC;
                    end else begin
                        state_q <= GEN_INC;
                    end
                end
                GEN_INC: begin
                    val_q     <= val_q + 1'b1;
                    enc_req_q <= 1'b1;
                    state_q   <= GEN_ENC;
                end
                GEN_ENC: begin
                    if (enc_ack) begin
                        enc_req_q    <= 1'b0;
                        rand_block_q <= enc_out;
                        rand_valid_q <= 1'b1;
                        state_q      <= GEN_OUT;
                    end
                end
                GEN_OUT: begin
                    if (rand_ready) begin
                        rand_valid_q <= 1'b0;
                        blk_cnt_q    <= blk_cnt_q - 1'b1;
                        if (blk_cnt_q == 5'd1) begin
                            rnd_q   <= '0;
                            state_q <= UPD_INC;
                        end else begin
                            state_q <= GEN_INC;
                        end
                    end
                end
                UPD_INC: begin
                    val_q     <= val_q + 1'b1;
                    enc_req_q <= 1'b1;
                    state_q   <= UPD_ENC;
                end
                UPD_ENC: begin
                    if (enc_ack) begin
                        enc_req_q <= 1'b0;
                        // Shift in so the first cipher output ends up most significant.
                        temp_q    <= {temp_q[SEEDLEN-BLKLEN-1:0], enc_out};
                        rnd_q     <= rnd_q + 1'b1;
                        state_q   <= (rnd_q == 2'd2) ? UPD_DONE : UPD_INC;
                    end
                end
                UPD_DONE: begin
                    key_q <= upd_seed[SEEDLEN-1:BLKLEN];
                    val_q <= upd_seed[BLKLEN-1:0];
                    if (pre_q) begin
                        pre_q   <= 1'b0;
                        state_q <= GEN_INC;
                    end else begin
                        ctr_q   <= ctr_q + 32'd1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gen_busy          = busy_q;
    assign enc_req           = enc_req_q;
    assign enc_key           = key_q;
    assign enc_in            = val_q;
    assign rand_block        = rand_block_q;
    assign rand_valid        = rand_valid_q;
    assign done              = done_q;
    assign req_error         = err_q;
    assign reseed_required   = rsd_q;
    assign key_out           = key_q;
    assign value_out         = val_q;
    assign reseedcounter_out = ctr_q;

endmodule

// File: tb/tb_generate_proc.sv
// Self-checking bench for generate_proc with a stub cipher (enc_in ^ enc_key[127:0]).
module tb_generate_proc;
    import drbg_pkg::*;

    localparam int unsigned MAXB = 16;
    localparam logic [31:0] RI   = 32'd1024;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] key_in = '0;
    logic [127:0] value_in = '0;
    logic [31:0]  reseedcounter_in = '0;
    logic         load = 1'b0;
    logic         gen_req = 1'b0;
    logic [4:0]   num_blocks = '0;
    logic         gen_busy, enc_req, rand_valid, done, reseed_required, req_error;
    logic [255:0] enc_key, key_out;
    logic [127:0] enc_in, rand_block, value_out;
    logic         enc_ack = 1'b0;
    logic [127:0] enc_out = '0;
    logic         rand_ready = 1'b0;
    logic [31:0]  reseedcounter_out;

    int n_tests = 0;
    int n_fail  = 0;
    int enc_calls = 0;
    int ack_limit = 1000000;
    logic late_ack = 1'b0;
    int stall_cycles = 0;
    int stable_err = 0;
    int stall_ctr = 0;
    int stub_wait = 0;
    int done_cnt = 0, err_cnt = 0, rsd_cnt = 0;
    logic [127:0] held_blk;
    logic [127:0] got_q[$];
    logic [127:0] exp_q[$];

    generate_proc dut (
        .clk(clk), .rst(rst), .key_in(key_in), .value_in(value_in),
        .reseedcounter_in(reseedcounter_in), .load(load), .gen_req(gen_req),
        .num_blocks(num_blocks), .gen_busy(gen_busy), .enc_req(enc_req),
        .enc_key(enc_key), .enc_in(enc_in), .enc_ack(enc_ack), .enc_out(enc_out),
        .rand_block(rand_block), .rand_valid(rand_valid), .rand_ready(rand_ready),
        .done(done), .reseed_required(reseed_required), .req_error(req_error),
        .key_out(key_out), .value_out(value_out), .reseedcounter_out(reseedcounter_out)
    );

    always #5 clk = ~clk;

    // Stub cipher: acknowledges after a random 0..3 cycle delay.
    always @(negedge clk) begin
        enc_ack = late_ack;
        if (enc_req && !late_ack && enc_calls < ack_limit) begin
            if (stub_wait == 0) begin
                enc_ack   = 1'b1;
                enc_out   = enc_in ^ enc_key[127:0];
                enc_calls++;
                stub_wait = int'($urandom_range(0, 3));
            end else begin
                stub_wait--;
            end
        end
    end

    // Output sink with programmable stall; also counts status pulses.
    always @(negedge clk) begin
        if (!rand_valid) begin
            stall_ctr  = 0;
            rand_ready = 1'b0;
        end else begin
            if (stall_ctr == 0) held_blk = rand_block;
            else if (rand_block !== held_blk) stable_err++;
            rand_ready = (stall_ctr >= stall_cycles);
            stall_ctr++;
            if (rand_ready) got_q.push_back(rand_block);
        end
        if (done) done_cnt++;
        if (req_error) err_cnt++;
        if (reseed_required) rsd_cnt++;
    end

    // Reference: kind 0 = generated, 1 = request error, 2 = reseed required.
    task automatic model_run(input logic [255:0] k, input logic [127:0] v, input logic [31:0] c,
                             input int nb, output logic [255:0] ko, output logic [127:0] vo,
                             output logic [31:0] co, output int kind);
        logic [383:0] temp;
        exp_q.delete();
        ko = k; vo = v; co = c; temp = '0;
        if (nb == 0 || nb > int'(MAXB)) kind = 1;
        else if (c > RI) kind = 2;
        else begin
            kind = 0;
            for (int i = 0; i < nb; i++) begin
                vo = vo + 128'd1;
                exp_q.push_back(vo ^ ko[127:0]);
            end
            for (int j = 0; j < 3; j++) begin
                vo = vo + 128'd1;
                temp[383-128*j -: 128] = vo ^ ko[127:0];
            end
            ko = temp[383:128];
            vo = temp[127:0];
            co = c + 32'd1;
        end
    endtask

    task automatic clear_counts();
        enc_calls = 0; done_cnt = 0; err_cnt = 0; rsd_cnt = 0; stable_err = 0;
        got_q.delete();
    endtask

    task automatic do_load(input logic [255:0] k, input logic [127:0] v, input logic [31:0] c);
        @(negedge clk);
        load = 1'b1; key_in = k; value_in = v; reseedcounter_in = c;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic run_gen(input logic [4:0] nb, input bit poke, output bit seen_done);
        @(negedge clk);
        gen_req = 1'b1; num_blocks = nb;
        @(negedge clk);
        gen_req = 1'b0; num_blocks = 5'($urandom);
        seen_done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            // Busy: these must all be ignored.
            if (poke && i == 2) begin
                load = 1'b1; gen_req = 1'b1; num_blocks = 5'd2;
                key_in = {8{$urandom}}; value_in = {4{$urandom}}; reseedcounter_in = $urandom;
            end else begin
                load = 1'b0; gen_req = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0; gen_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_run(input string name, input logic [255:0] k, input logic [127:0] v,
                             input logic [31:0] c, input int nb, input bit poke);
        logic [255:0] ek; logic [127:0] ev; logic [31:0] ec; int kind; bit sd;
        clear_counts();
        do_load(k, v, c);
        model_run(k, v, c, nb, ek, ev, ec, kind);
        run_gen(5'(nb), poke, sd);
        n_tests++;
        if (sd !== 1'b1) begin n_fail++; $display("FAIL %s done_timeout got=%0b want=1", name, sd); end
        n_tests++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL %s done_count got=%0d want=1", name, done_cnt); end
        n_tests++;
        if (err_cnt != (kind == 1 ? 1 : 0)) begin
            n_fail++; $display("FAIL %s req_error got=%0d want=%0d", name, err_cnt, kind == 1);
        end
        n_tests++;
        if (rsd_cnt != (kind == 2 ? 1 : 0)) begin
            n_fail++; $display("FAIL %s reseed_req got=%0d want=%0d", name, rsd_cnt, kind == 2);
        end
        n_tests++;
        if (enc_calls != (kind == 0 ? nb + 3 : 0)) begin
            n_fail++; $display("FAIL %s enc_calls got=%0d want=%0d", name, enc_calls,
                               kind == 0 ? nb + 3 : 0);
        end
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL %s block_count got=%0d want=%0d", name, got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL %s block%0d got=%h want=%h", name, i, got_q[i], exp_q[i]);
                end
            end
        end
        n_tests++;
        if (key_out !== ek || value_out !== ev || reseedcounter_out !== ec) begin
            n_fail++; $display("FAIL %s state got=%h/%h/%0d want=%h/%h/%0d", name,
                               key_out, value_out, reseedcounter_out, ek, ev, ec);
        end
        n_tests++;
        if (gen_busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_after got=%0b want=0", name, gen_busy); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (key_out !== '0 || value_out !== '0) begin
            n_fail++; $display("FAIL reset_kv got=%h/%h want=0/0", key_out, value_out);
        end
        n_tests++;
        if (reseedcounter_out !== 32'd1) begin
            n_fail++; $display("FAIL reset_ctr got=%0d want=1", reseedcounter_out);
        end
        n_tests++;
        if ({gen_busy, enc_req, rand_valid, done, req_error, reseed_required} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags got=%b want=000000",
                               {gen_busy, enc_req, rand_valid, done, req_error, reseed_required});
        end
        n_tests++;
        if (rand_block !== '0) begin n_fail++; $display("FAIL reset_block got=%h want=0", rand_block); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_known();
        check_run("known", 256'h0, 128'h0, 32'd1, 1, 1'b0);
        n_tests++;
        if (key_out !== {128'h2, 128'h3} || value_out !== 128'h4 || reseedcounter_out !== 32'd2) begin
            n_fail++; $display("FAIL known_vec got=%h/%h/%0d want=2,3/4/2", key_out, value_out,
                               reseedcounter_out);
        end
    endtask

    task automatic test_wrap();
        check_run("wrap", 256'h0, {128{1'b1}}, 32'd1, 1, 1'b0);
        n_tests++;
        if (value_out !== 128'h3) begin n_fail++; $display("FAIL wrap_v got=%h want=3", value_out); end
    endtask

    task automatic test_reseed();
        check_run("reseed", {8{$urandom}}, {4{$urandom}}, RI + 32'd1, 4, 1'b0);
        check_run("at_limit", {8{$urandom}}, {4{$urandom}}, RI, 2, 1'b0);
    endtask

    task automatic test_error();
        check_run("nb0", {8{$urandom}}, {4{$urandom}}, 32'd5, 0, 1'b0);
        check_run("nb17", {8{$urandom}}, {4{$urandom}}, 32'd5, 17, 1'b0);
        check_run("nb16", {8{$urandom}}, {4{$urandom}}, 32'd5, 16, 1'b0);
    endtask

    task automatic test_load_priority();
        logic [255:0] k; logic [127:0] v; logic [31:0] c;
        k = {8{$urandom}}; v = {4{$urandom}}; c = $urandom_range(1, 100);
        clear_counts();
        @(negedge clk);
        load = 1'b1; gen_req = 1'b1; num_blocks = 5'd1;
        key_in = k; value_in = v; reseedcounter_in = c;
        @(negedge clk);
        load = 1'b0; gen_req = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (gen_busy !== 1'b0 || enc_calls != 0 || done_cnt != 0) begin
            n_fail++; $display("FAIL load_prio activity got=%0b/%0d/%0d want=0/0/0", gen_busy,
                               enc_calls, done_cnt);
        end
        n_tests++;
        if (key_out !== k || value_out !== v || reseedcounter_out !== c) begin
            n_fail++; $display("FAIL load_prio state got=%h/%h/%0d want=%h/%h/%0d", key_out,
                               value_out, reseedcounter_out, k, v, c);
        end
    endtask

    task automatic test_stall();
        stall_cycles = 5;
        check_run("stall", {8{$urandom}}, {4{$urandom}}, 32'd7, 3, 1'b0);
        n_tests++;
        if (stable_err != 0) begin n_fail++; $display("FAIL stall_stable got=%0d want=0", stable_err); end
        stall_cycles = 0;
    endtask

    task automatic test_random();
        logic [127:0] v; logic [31:0] c;
        for (int it = 0; it < 10; it++) begin
            v = ($urandom_range(0, 3) == 0) ? ({128{1'b1}} - 128'($urandom_range(0, 3)))
                                             : {4{$urandom}};
            case ($urandom_range(0, 3))
                0: c = RI;
                1: c = RI + 32'd1;
                default: c = $urandom_range(1, 900);
            endcase
            stall_cycles = int'($urandom_range(0, 2));
            check_run("random", {8{$urandom}}, v, c, int'($urandom_range(0, 18)),
                      1'($urandom_range(0, 1)));
        end
        stall_cycles = 0;
    endtask

    task automatic test_abort();
        bit reached;
        clear_counts();
        ack_limit = 2;
        do_load({8{$urandom}}, {4{$urandom}}, 32'd1);
        @(negedge clk);
        gen_req = 1'b1; num_blocks = 5'd1;
        @(negedge clk);
        gen_req = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (enc_calls == 2 && enc_req) begin reached = 1'b1; break; end
            @(negedge clk);
        end
        n_tests++;
        if (reached !== 1'b1) begin n_fail++; $display("FAIL abort_reach got=%0b want=1", reached); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        late_ack = 1'b1;
        @(negedge clk);
        late_ack = 1'b0;
        repeat (4) @(negedge clk);
        ack_limit = 1000000;
        n_tests++;
        if (key_out !== '0 || value_out !== '0 || reseedcounter_out !== 32'd1) begin
            n_fail++; $display("FAIL abort_state got=%h/%h/%0d want=0/0/1", key_out, value_out,
                               reseedcounter_out);
        end
        n_tests++;
        if (done_cnt != 0) begin n_fail++; $display("FAIL abort_done got=%0d want=0", done_cnt); end
        n_tests++;
        if ({gen_busy, enc_req, rand_valid} !== 3'b0) begin
            n_fail++; $display("FAIL abort_flags got=%b want=000", {gen_busy, enc_req, rand_valid});
        end
    endtask

    initial begin
        test_reset();
        test_known();
        test_wrap();
        test_reseed();
        test_error();
        test_load_priority();
        test_stall();
        test_random();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/generate_proc.md
GENERATE_PROC -- requirements
Module: generate_proc

Interface
REQ-001 SHALL have parameter RESEED_INTERVAL, default 32'd1024, maximum generate requests between reseeds.
REQ-002 SHALL have parameter MAX_BLOCKS, default 16, maximum 128-bit output blocks per request.
REQ-003 SHALL have port clk, input, 1, single rising-edge clock.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have ports key_in, value_in and reseedcounter_in, inputs of 256, 128 and 32 bits, working state from the instantiate or reseed procedure.
REQ-006 SHALL have port load, input, 1, copies key_in, value_in and reseedcounter_in into the internal state.
REQ-007 SHALL have ports gen_req, input, 1, and num_blocks, input, 5, a generate request with a block count.
REQ-008 SHALL have port gen_busy, output, 1, high from request acceptance until done.
REQ-009 SHALL have ports enc_req (output, 1), enc_key (output, 256), enc_in (output, 128), enc_ack (input, 1) and enc_out (input, 128), the external AES-256 handshake.
REQ-010 SHALL have ports rand_block (output, 128), rand_valid (output, 1) and rand_ready (input, 1), the output stream.
REQ-011 SHALL have ports done (output, 1), reseed_required (output, 1) and req_error (output, 1), one-cycle completion and status pulses.
REQ-012 SHALL have ports key_out (output, 256), value_out (output, 128) and reseedcounter_out (output, 32), the current state, always driven.

Function
REQ-013 SHALL use FSM states IDLE, CHECK, GEN_INC, GEN_ENC, GEN_OUT, UPD_INC, UPD_ENC, UPD_DONE.
REQ-014 IDLE: load SHALL update state in one cycle; if load and gen_req are both high, load wins and gen_req is ignored.
REQ-015 IDLE: gen_req SHALL latch num_blocks, go to CHECK and raise gen_busy.
REQ-016 CHECK: num_blocks==0 or >MAX_BLOCKS SHALL pulse req_error and done and return to IDLE, with state unchanged.
REQ-017 CHECK: reseedcounter>RESEED_INTERVAL SHALL pulse reseed_required and done, with no output and state unchanged.
REQ-018 GEN_INC/UPD_INC: V SHALL become V+1 mod 2^128, wrapping all-ones to zero.
REQ-019 GEN_ENC/UPD_ENC: enc_req SHALL be held high with stable enc_key=K and enc_in=V until the cycle enc_ack is sampled high; one transaction at a time.
REQ-020 GEN_OUT: rand_block=enc_out and rand_valid high SHALL be held until rand_ready, then the block counter decrements; when it reaches 0 go to UPD_INC, else GEN_INC.
REQ-021 Update SHALL run 3 INC/ENC rounds forming temp={E1,E2,E3} (384 bits, E1 most significant); UPD_DONE sets K=temp[383:128], V=temp[127:0], reseedcounter+1, pulses done and returns to IDLE.
REQ-022 load, gen_req and num_blocks SHALL be ignored while gen_busy.

Reset
REQ-023 On rst: K=0, V=0, reseedcounter=1, FSM=IDLE, and every output low or zero except key_out, value_out and reseedcounter_out, which reflect the reset state.
REQ-024 rst mid-operation SHALL abort immediately, drop enc_req and rand_valid, and emit no done; a late enc_ack is ignored.

Configuration
REQ-025 With DRBG_ADDIN_EN defined: port addin (input, 384) SHALL be latched at gen_req; if it is nonzero, an update(addin) runs before GEN_INC and temp is XORed with addin in the final update.
REQ-026 Without DRBG_ADDIN_EN: no addin port, and the final update SHALL use an all-zero additional input.

Structure
REQ-027 Package drbg_pkg SHALL hold the KEYLEN=256, BLKLEN=128, SEEDLEN=384 constants, the FSM state enum and the default RESEED_INTERVAL; it is shared with instantiation and reseed.
REQ-028 No sub-module: the cipher is external, and the FSM, counters and datapath live in generate_proc.

Verification (bench stub cipher: enc_out = enc_in ^ enc_key[127:0])
REQ-029 rst, load K=0 V=0 ctr=1, gen_req with num_blocks=1 -> rand_block=128'h1, then K={128'h2,128'h3}, V=128'h4, ctr=2, done pulses.
REQ-030 load V=all-ones K=0, num_blocks=1 -> rand_block=0, final V=128'h3.
REQ-031 load ctr=RESEED_INTERVAL+1, gen_req -> reseed_required and done pulse, no enc_req, state unchanged.
REQ-032 num_blocks=0 and num_blocks=17 -> req_error and done each, no enc_req.
REQ-033 num_blocks=3 with rand_ready low for 5 cycles per block -> rand_block stable while stalled, exactly 3 handshakes, then 3 update cipher calls.
REQ-034 rst asserted during UPD_ENC with enc_ack delayed -> after reset K=0, V=0, ctr=1, no done, late enc_ack ignored.
